// File: rtl/iter_adder_pkg.sv
// Shared types and helpers for the iterative XOR/AND carry adder.
package iter_adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int MIN_WIDTH = 2;
  localparam int MIN_ITERS = 1;

  // Width of the iteration counter; it must be able to hold WIDTH itself.
  function automatic int iter_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic bit params_legal(input int width, input int ipc);
    return (width >= MIN_WIDTH) && (ipc >= MIN_ITERS) && (ipc <= width);
  endfunction

endpackage

// File: rtl/iter_adder_if.sv
// Operand/result handshake bundle for iter_adder.
interface iter_adder_if
  import iter_adder_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int IW = iter_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic [IW-1:0]    iters;

  modport master (
    output in_valid, op1, op2, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, iters
  );

  modport slave (
    input  in_valid, op1, op2, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, iters
  );

endinterface

// File: rtl/iter_add_step.sv
// One combinational carry-iteration step: fold the carry into the sum, regenerate the carry.
module iter_add_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH:0]   c,
  output logic [WIDTH-1:0] s_nxt,
  output logic [WIDTH:0]   c_nxt,
  output logic             co,
  output logic             active
);

  // c[WIDTH] is the carry already pushed past the MSB; report it before it is shifted out.
  assign co     = c[WIDTH];
  assign active = |c[WIDTH-1:0];
  assign s_nxt  = s ^ c[WIDTH-1:0];
  assign c_nxt  = {s & c[WIDTH-1:0], 1'b0};

endmodule

// File: rtl/iter_adder.sv
// Multi-cycle adder/subtractor that iterates sum^carry until the carry vector is empty.
module iter_adder
  import iter_adder_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int ITERS_PER_CYCLE = 1
) (
  input logic         clk,
  input logic         rst_n,
  iter_adder_if.slave bus
);

  localparam int IW = iter_w(WIDTH);

  if (!params_legal(WIDTH, ITERS_PER_CYCLE)) begin : g_bad_params
    $error("iter_adder: WIDTH must be >= 2 and ITERS_PER_CYCLE in 1..WIDTH");
  end

  state_e state_q, state_d;

  logic [WIDTH-1:0] s_q;
  logic [WIDTH:0]   c_q;
  logic             cout_acc_q;
  logic             op1_msb_q;
  logic             b_msb_q;
  logic [IW-1:0]    iters_q;

  logic             accept;
  logic             done;
  logic [WIDTH-1:0] b_load;
  logic [WIDTH:0]   c_load;

  logic [ITERS_PER_CYCLE:0][WIDTH-1:0] s_ch;
  logic [ITERS_PER_CYCLE:0][WIDTH:0]   c_ch;
  logic [ITERS_PER_CYCLE-1:0]          co_ch;
  logic [ITERS_PER_CYCLE-1:0]          act_ch;

  logic [IW-1:0] step_cnt;
  logic [IW:0]   iters_sum;
  logic [IW-1:0] iters_nxt;

  assign accept = bus.in_valid && bus.in_ready;
  assign b_load = bus.sub ? ~bus.op2 : bus.op2;
  // The subtract "+1" enters as the carry into bit 0.
  assign c_load = {bus.op1 & b_load, bus.sub};

  assign s_ch[0] = s_q;
  assign c_ch[0] = c_q;

  for (genvar g = 0; g < ITERS_PER_CYCLE; g++) begin : g_step
    iter_add_step #(.WIDTH(WIDTH)) u_step (
      .s      (s_ch[g]),
      .c      (c_ch[g]),
      .s_nxt  (s_ch[g+1]),
      .c_nxt  (c_ch[g+1]),
      .co     (co_ch[g]),
      .active (act_ch[g])
    );
  end

  always_comb begin
    step_cnt = '0;
    for (int i = 0; i < ITERS_PER_CYCLE; i++) begin
      step_cnt = step_cnt + IW'(act_ch[i]);
    end
  end

  assign iters_sum = {1'b0, iters_q} + {1'b0, step_cnt};
  assign iters_nxt = (iters_sum > (IW+1)'(WIDTH)) ? IW'(WIDTH) : iters_sum[IW-1:0];

  always_comb begin
    // NOTE: assign every combinational output a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (c_load[WIDTH-1:0] == '0) ? DONE : RUN;
      RUN:     if (c_ch[ITERS_PER_CYCLE][WIDTH-1:0] == '0) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= '0;
      c_q        <= '0;
      cout_acc_q <= 1'b0;
      op1_msb_q  <= 1'b0;
      b_msb_q    <= 1'b0;
      iters_q    <= '0;
    end else if (accept) begin
      s_q        <= bus.op1 ^ b_load;
      c_q        <= c_load;
      cout_acc_q <= 1'b0;
      op1_msb_q  <= bus.op1[WIDTH-1];
      b_msb_q    <= b_load[WIDTH-1];
      iters_q    <= '0;
    end else if (state_q == RUN) begin
      s_q        <= s_ch[ITERS_PER_CYCLE];
      c_q        <= c_ch[ITERS_PER_CYCLE];
      cout_acc_q <= cout_acc_q | (|co_ch);
      iters_q    <= iters_nxt;
    end
  end

  // Results are gated by DONE so an aborted or in-flight operation never leaks out.
  assign done          = (state_q == DONE);
  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = done;
  assign bus.sum       = done ? s_q : '0;
  assign bus.cout      = done && (cout_acc_q || c_q[WIDTH]);
  assign bus.overflow  = done && (op1_msb_q == b_msb_q) && (s_q[WIDTH-1] != op1_msb_q);
  assign bus.iters     = done ? iters_q : '0;

  a_iters_bound: assert property (@(posedge clk) disable iff (!rst_n) iters_q <= IW'(WIDTH));

endmodule

// File: tb/tb_iter_adder.sv
// Directed and reference-model checks for iter_adder at several WIDTH/ITERS_PER_CYCLE points.
module tb_iter_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   sel = 0;

  always #5 clk = ~clk;

  iter_adder_if #(.WIDTH(8))  if_a ();
  iter_adder_if #(.WIDTH(8))  if_b ();
  iter_adder_if #(.WIDTH(16)) if_c ();
  iter_adder_if #(.WIDTH(32)) if_d ();

  iter_adder #(.WIDTH(8),  .ITERS_PER_CYCLE(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  iter_adder #(.WIDTH(8),  .ITERS_PER_CYCLE(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  iter_adder #(.WIDTH(16), .ITERS_PER_CYCLE(3)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  iter_adder #(.WIDTH(32), .ITERS_PER_CYCLE(1)) u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  logic        m_in_ready;
  logic        m_out_valid;
  logic [31:0] m_sum;
  logic        m_cout;
  logic        m_ovf;
  logic [5:0]  m_iters;

  always_comb begin
    m_in_ready  = 1'b0;
    m_out_valid = 1'b0;
    m_sum       = '0;
    m_cout      = 1'b0;
    m_ovf       = 1'b0;
    m_iters     = '0;
    case (sel)
      0: begin
        m_in_ready = if_a.in_ready; m_out_valid = if_a.out_valid; m_sum = 32'(if_a.sum);
        m_cout = if_a.cout; m_ovf = if_a.overflow; m_iters = 6'(if_a.iters);
      end
      1: begin
        m_in_ready = if_b.in_ready; m_out_valid = if_b.out_valid; m_sum = 32'(if_b.sum);
        m_cout = if_b.cout; m_ovf = if_b.overflow; m_iters = 6'(if_b.iters);
      end
      2: begin
        m_in_ready = if_c.in_ready; m_out_valid = if_c.out_valid; m_sum = 32'(if_c.sum);
        m_cout = if_c.cout; m_ovf = if_c.overflow; m_iters = 6'(if_c.iters);
      end
      3: begin
        m_in_ready = if_d.in_ready; m_out_valid = if_d.out_valid; m_sum = if_d.sum;
        m_cout = if_d.cout; m_ovf = if_d.overflow; m_iters = if_d.iters;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input int s, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic sb);
    case (s)
      0: begin if_a.in_valid = v; if_a.op1 = a[7:0];  if_a.op2 = b[7:0];  if_a.sub = sb; end
      1: begin if_b.in_valid = v; if_b.op1 = a[7:0];  if_b.op2 = b[7:0];  if_b.sub = sb; end
      2: begin if_c.in_valid = v; if_c.op1 = a[15:0]; if_c.op2 = b[15:0]; if_c.sub = sb; end
      3: begin if_d.in_valid = v; if_d.op1 = a;       if_d.op2 = b;       if_d.sub = sb; end
      default: ;
    endcase
  endtask

  task automatic set_ordy(input int s, input logic r);
    case (s)
      0: if_a.out_ready = r;
      1: if_b.out_ready = r;
      2: if_c.out_ready = r;
      3: if_d.out_ready = r;
      default: ;
    endcase
  endtask

  // Present one operation, then wait (bounded) for out_valid; lat counts the accept edge as 1.
  task automatic run_op(input int s, input logic [31:0] a, input logic [31:0] b, input logic sb,
                        output int lat);
    sel = s;
    #1;
    check("in_ready_idle", m_in_ready, 1'b1);
    set_in(s, 1'b1, a, b, sb);
    @(posedge clk);
    #1;
    set_in(s, 1'b0, a, b, sb);
    lat = 1;
    while (!m_out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_valid_reached", m_out_valid, 1'b1);
  endtask

  task automatic check_res(input string tag, input logic [31:0] esum, input logic ecout,
                           input logic eovf, input int eiters, input int lat, input int elat);
    check({tag, ".sum"},      m_sum,   esum);
    check({tag, ".cout"},     m_cout,  ecout);
    check({tag, ".overflow"}, m_ovf,   eovf);
    check({tag, ".iters"},    m_iters, 64'(eiters));
    check({tag, ".latency"},  64'(lat), 64'(elat));
  endtask

  task automatic release_out();
    set_ordy(sel, 1'b1);
    @(posedge clk);
    #1;
    check("release.in_ready",  m_in_ready,  1'b1);
    check("release.out_valid", m_out_valid, 1'b0);
    set_ordy(sel, 1'b0);
  endtask

  // Arithmetic reference plus the carry-step count that the iteration needs.
  task automatic ref_add(input int w, input logic [63:0] a, input logic [63:0] b, input logic sb,
                         output logic [63:0] rsum, output logic rcout, output logic rovf,
                         output int rk);
    logic [63:0] mask, bb, full, s, c, cm, t;
    mask  = (64'd1 << w) - 64'd1;
    bb    = sb ? (~b & mask) : (b & mask);
    full  = (a & mask) + bb + 64'(sb);
    rsum  = full & mask;
    rcout = full[w];
    rovf  = (a[w-1] == bb[w-1]) && (rsum[w-1] != a[w-1]);
    s  = (a ^ bb) & mask;
    c  = ((a & bb & mask) << 1) | 64'(sb);
    cm = c & mask;
    rk = 0;
    while (cm != 64'd0) begin
      t  = s & cm;
      s  = s ^ cm;
      cm = (t << 1) & mask;
      rk++;
    end
  endtask

  int          lat;
  logic [63:0] rsum;
  logic        rcout, rovf, le;
  int          rk, w, ipc;
  logic [31:0] ra, rb;

  initial begin
    for (int s = 0; s < 4; s++) begin
      set_in(s, 1'b0, '0, '0, 1'b0);
      set_ordy(s, 1'b0);
    end

    #2;
    check("reset.in_ready",  m_in_ready,  1'b0);
    check("reset.out_valid", m_out_valid, 1'b0);
    check("reset.sum",       m_sum,       '0);
    check("reset.cout",      m_cout,      1'b0);
    check("reset.overflow",  m_ovf,       1'b0);
    check("reset.iters",     m_iters,     '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(0, 32'h03, 32'h01, 1'b0, lat); check_res("add03_01", 32'h04, 1'b0, 1'b0, 2, lat, 3); release_out();
    run_op(0, 32'hFF, 32'h01, 1'b0, lat); check_res("addFF_01", 32'h00, 1'b1, 1'b0, 7, lat, 8); release_out();
    run_op(1, 32'hFF, 32'h01, 1'b0, lat); check_res("addFF_01_x4", 32'h00, 1'b1, 1'b0, 7, lat, 3); release_out();
    run_op(0, 32'h80, 32'h80, 1'b0, lat); check_res("add80_80", 32'h00, 1'b1, 1'b1, 0, lat, 1); release_out();
    run_op(0, 32'h7F, 32'h01, 1'b0, lat); check_res("add7F_01", 32'h80, 1'b0, 1'b1, 7, lat, 8); release_out();
    run_op(0, 32'h05, 32'h03, 1'b1, lat); check_res("sub5_3", 32'h02, 1'b1, 1'b0, 5, lat, 6); release_out();
    run_op(0, 32'h03, 32'h05, 1'b1, lat); check_res("sub3_5", 32'hFE, 1'b0, 1'b0, 2, lat, 3); release_out();
    run_op(2, 32'hFFFF, 32'h0001, 1'b0, lat); check_res("addFFFF_1_w16", 32'h0, 1'b1, 1'b0, 15, lat, 6); release_out();

    // Back-pressure: result must hold and in_valid pulses must not be taken.
    run_op(0, 32'h03, 32'h01, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1'b1, 32'hAA, 32'h55, 1'b1);
      @(posedge clk);
      #1;
      set_in(0, 1'b0, 32'hAA, 32'h55, 1'b1);
      check("hold.sum",       m_sum,       32'h04);
      check("hold.out_valid", m_out_valid, 1'b1);
      check("hold.in_ready",  m_in_ready,  1'b0);
      check("hold.iters",     m_iters,     6'd2);
    end
    release_out();

    // Abort a long operation with reset partway through RUN.
    sel = 0;
    set_in(0, 1'b1, 32'hFF, 32'h01, 1'b0);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 32'hFF, 32'h01, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("midrun.in_ready", m_in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort.in_ready",  m_in_ready,  1'b0);
    check("abort.out_valid", m_out_valid, 1'b0);
    check("abort.sum",       m_sum,       '0);
    check("abort.cout",      m_cout,      1'b0);
    check("abort.iters",     m_iters,     '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort.idle_ready", m_in_ready,  1'b1);
    check("abort.no_result",  m_out_valid, 1'b0);
    run_op(0, 32'h10, 32'h20, 1'b0, lat); check_res("add10_20", 32'h30, 1'b0, 1'b0, 0, lat, 1); release_out();

    // Wider instances against the arithmetic reference.
    for (int s = 2; s <= 3; s++) begin
      w   = (s == 2) ? 16 : 32;
      ipc = (s == 2) ? 3 : 1;
      for (int n = 0; n < 8; n++) begin
        ra = $urandom;
        rb = $urandom;
        if (n == 6) rb = ra;
        ref_add(w, 64'(ra), 64'(rb), n[0], rsum, rcout, rovf, rk);
        run_op(s, ra, rb, n[0], lat);
        check_res("rnd", rsum[31:0], rcout, rovf, rk, lat, 1 + (rk + ipc - 1) / ipc);
        le = (int'(m_iters) <= w);
        check("rnd.iters_le_width", le, 1'b1);
        release_out();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_adder.md
Name: iter_adder

Overview:
- Multi-cycle, parametrised successor to the team's 8-bit XOR/AND carry-iteration adder.
- Iterates sum = s^c, carry = (s&c)<<1 until the carry vector is zero, rather than running a fixed three rounds, so every result is exact at any width.
- Adds subtract mode, carry-out, signed overflow and an iteration count.
- Sits behind a valid/ready handshake on each side. Used as a low-area arithmetic unit in the crossbar datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 2.
- ITERS_PER_CYCLE, 1, carry-iteration steps evaluated combinationally per clock; legal range 1..WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- op1  in  WIDTH  first operand.
- op2  in  WIDTH  second operand.
- sub  in  1  0: op1+op2; 1: op1-op2 (two's complement).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result modulo 2^WIDTH.
- cout  out  1  carry out of the MSB; in subtract mode, 1 = no borrow.
- overflow  out  1  signed overflow.
- iters  out  $clog2(WIDTH+1)  number of effective carry steps taken.

Behaviour:
- Reset (async assert, sync release): state IDLE. in_ready=0 while rst_n is low, then 1. out_valid, sum, cout, overflow and iters are all 0.
- Reset mid-operation aborts the operation; no partial result is ever presented.
- FSM states and transitions:
  - IDLE: in_ready=1. Accept on in_valid&in_ready.
    - Let b = sub ? ~op2 : op2.
    - Load s = op1^b (WIDTH bits) and c = {op1&b, sub} (WIDTH+1 bits).
    - Set cout_acc = 0 and latch op1[MSB] and b[MSB].
    - If c[WIDTH-1:0]==0, go to DONE; otherwise go to RUN.
  - RUN: each cycle apply ITERS_PER_CYCLE chained steps. One step is:
    - cout_acc |= c[WIDTH]
    - s' = s ^ c[WIDTH-1:0]
    - c' = {s & c[WIDTH-1:0], 1'b0}
    - A step whose incoming c[WIDTH-1:0] is 0 is a no-op and does not increment iters.
    - Go to DONE when the resulting c[WIDTH-1:0]==0.
  - DONE: out_valid=1. sum=s, cout = cout_acc | c[WIDTH], overflow = (op1msb==bmsb) && (s[MSB]!=op1msb), iters = effective step count.
    - Outputs are held stable until out_ready. On out_valid&out_ready, go to IDLE: out_valid drops and in_ready rises on the next cycle.
- in_ready is 0 in RUN and DONE. in_valid in those states is ignored and operands are not sampled. Operands need be stable only on the accept edge.
- Effective steps k <= WIDTH, because the carry vector gains one trailing zero per step.
- Latency from accept edge to out_valid high = 1 + ceil(k/ITERS_PER_CYCLE) cycles.
- Throughput is one operation per (latency+1) cycles minimum. There is no overlap of operations.
- iters saturates at WIDTH (never exceeded by construction; an assertion checks this).

Decomposition:
- Package iter_adder_pkg:
  - state enum {IDLE, RUN, DONE}
  - function iter_w(width) = $clog2(width+1)
  - parameter-legality check constants
- Sub-module iter_add_step: combinational single step.
  - Inputs: s, c. Outputs: s', c', carry-out bit, active flag.
  - Instantiated ITERS_PER_CYCLE times in a generate chain inside iter_adder.

Test Plan:
- WIDTH=8, ITERS=1: 8'h03+8'h01 -> sum=8'h04, cout=0, overflow=0, iters=2, out_valid 3 cycles after accept.
- WIDTH=8, ITERS=1: 8'hFF+8'h01 -> sum=8'h00, cout=1, overflow=0, iters=7, latency 8 cycles. Repeat with ITERS=4 -> same result, latency 3.
- WIDTH=8: 8'h80+8'h80 -> sum=8'h00, cout=1, overflow=1, iters=0, latency 1. Also 8'h7F+8'h01 -> sum=8'h80, overflow=1, cout=0.
- WIDTH=8, sub=1: 5-3 -> sum=8'h02, cout=1, iters=5. Also 3-5 -> sum=8'hFE, cout=0, overflow=0.
- Handshake: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> in_ready=1 the next cycle.
- Assert rst_n low mid-RUN (during 8'hFF+8'h01) -> all outputs 0 immediately. After release, 8'h10+8'h20 -> sum=8'h30, iters=0.
- WIDTH=16 and WIDTH=32: random add and subtract vs reference model. Check iters <= WIDTH and latency formula.
